id_ex_stage: RTL

- Pipeline register between decode/register-file read and execute.
- Captures decoded control, immediate and the register file's combinational read data (rd1/rd2).
- Bypasses same-cycle writeback data, because the register file write lands only at the clock edge.
- Detects load-use hazards: inserts one bubble and stalls decode. Honours branch flush and downstream backpressure.

---
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with writeback bypass, load-use bubble and flush
//
// Purpose:
//   Registers the decoded instruction between decode/register-file read and
//   execute. Source operands come from the register file's combinational read
//   ports. They are bypassed from the writeback port when writeback targets the
//   same register in the same cycle, because the register file write lands
//   only at the clock edge. A load in EX whose destination is read by the
//   decode slot causes a single bubble. A taken branch flushes both slots.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid / id_ready             decode slot handshake
//   id_pc, id_rs1, id_rs2, id_rd    decode instruction fields
//   id_imm, id_alu_op, id_* ctrl    immediate, ALU op and control bits
//   rf_rd1, rf_rd2                  register file read data for id_rs1/id_rs2
//   wb_reg_write, wb_rd, wb_data    writeback port, used for bypass/refresh
//   ex_flush                        kill EX slot and decode slot
//   ex_ready                        execute accepts the EX slot
//   ex_valid, ex_*                  registered EX slot
//   perf_stall_cnt, perf_bubble_cnt performance counters
//
// Configuration:
//   ID_EX_PERF_EN  when defined, the performance counters are implemented;
//                  otherwise both counter ports are tied to 0.

module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [RA_W-1:0]     id_rs1,
  input  logic [RA_W-1:0]     id_rs2,
  input  logic [RA_W-1:0]     id_rd,
  input  logic [XLEN-1:0]     id_imm,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_alu_src,
  input  logic                id_mem_to_reg,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [XLEN-1:0]     rf_rd1,
  input  logic [XLEN-1:0]     rf_rd2,
  input  logic                wb_reg_write,
  input  logic [RA_W-1:0]     wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                ex_flush,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_imm,
  output logic [XLEN-1:0]     ex_op_a,
  output logic [XLEN-1:0]     ex_op_b,
  output logic [RA_W-1:0]     ex_rs1,
  output logic [RA_W-1:0]     ex_rs2,
  output logic [RA_W-1:0]     ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_alu_src,
  output logic                ex_mem_to_reg,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_bubble_cnt
);

  logic            adv;
  logic            load_use;
  logic            wb_hit_rs1;
  logic            wb_hit_rs2;
  logic            wb_hit_ex_rs1;
  logic            wb_hit_ex_rs2;
  logic [XLEN-1:0] op_a_sel;
  logic [XLEN-1:0] op_b_sel;

  // The EX slot can take a new entry when it is empty or being consumed.
  assign adv = ~ex_valid | ex_ready;

  assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign id_ready = adv & ~load_use & ~ex_flush;

  // Writeback to x0 is never a real write, so it never bypasses.
  assign wb_hit_rs1    = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs1);
  assign wb_hit_rs2    = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs2);
  assign wb_hit_ex_rs1 = wb_reg_write & (wb_rd != '0) & (wb_rd == ex_rs1);
  assign wb_hit_ex_rs2 = wb_reg_write & (wb_rd != '0) & (wb_rd == ex_rs2);

  always_comb begin
    op_a_sel = rf_rd1;
    op_b_sel = rf_rd2;
    if (id_rs1 == '0)    op_a_sel = '0;
    else if (wb_hit_rs1) op_a_sel = wb_data;
    if (id_rs2 == '0)    op_b_sel = '0;
    else if (wb_hit_rs2) op_b_sel = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_imm        <= '0;
      ex_op_a       <= '0;
      ex_op_b       <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_op     <= '0;
    end else if (ex_flush || (adv && load_use)) begin
      // Flush or load-use bubble: empty slot, controls cleared, data held.
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_op     <= '0;
    end else if (adv) begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_imm        <= id_imm;
      ex_op_a       <= op_a_sel;
      ex_op_b       <= op_b_sel;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_reg_write  <= id_reg_write  & id_valid;
      ex_mem_read   <= id_mem_read   & id_valid;
      ex_mem_write  <= id_mem_write  & id_valid;
      ex_alu_src    <= id_alu_src    & id_valid;
      ex_mem_to_reg <= id_mem_to_reg & id_valid;
      ex_alu_op     <= id_valid ? id_alu_op : '0;
    end else if (ex_valid) begin
      // Stalled in EX: keep operands current with writebacks that land while
      // waiting, otherwise the held value would go stale.
      if (wb_hit_ex_rs1) ex_op_a <= wb_data;
      if (wb_hit_ex_rs2) ex_op_b <= wb_data;
    end
  end

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (id_valid && !id_ready && !ex_flush) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (adv && load_use && !ex_flush)       perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule
